cpu_trace_checker: RTL and testbench
====================================

# cpu_trace_checker

Parametrised line checker for the CPU trace character stream, one character per valid cycle. It parses register-write lines `^<time>@<pc>: $<grf> <= <data>#` and memory-write lines `^<time>@<pc>: *<addr> <= <data>#`. For each well-formed line it reports the format type and a per-field error vector. It sits beside the trace UART receiver and replaces the fixed-range checker; ranges and digit limits are parameters, and it adds a `$0` write check, restart on `^` from any state, and registered results.

## Interface
- TIME_DIGITS, 4, max decimal digits of time (min 1)
- TIME_W, 16, time accumulator width; accumulation wraps modulo 2^TIME_W
- GRF_DIGITS, 4, max decimal digits of grf (min 1)
- GRF_MAX, 31, highest legal register number
- PC_LO / PC_HI, 32'h3000 / 32'h4fff, inclusive legal pc range
- ADDR_LO / ADDR_HI, 32'h0 / 32'h2fff, inclusive legal addr range
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- char_valid  in  1  char is present this cycle; no backpressure, always accepted
- char  in  8  ASCII character
- freq  in  16  clock frequency; guaranteed power of two, ≥2
- result_valid  out  1  one-cycle pulse: a line completed
- format_type  out  2  01 register line, 10 memory line, 00 none
- error_code  out  5  bit0 time, bit1 pc, bit2 addr, bit3 grf, bit4 nonzero data to $0
- line_count  out  16  completed lines (stats)
- err_line_count  out  16  completed lines with error_code≠0 (stats)

## Operation
- States: IDLE, TIME, PC, SP_A, GRF, ADDR, SP_B, ARROW, SP_C, DATA. Cycles with char_valid=0 change nothing.
- `^` in any state, including mid-line: clear all field accumulators, clear the pending error, enter TIME. Any other illegal char: enter IDLE and drop the line silently.
- Decimal chars are 0-9. Hex chars are 0-9 and a-f; uppercase is illegal.
- TIME: accepts 1..TIME_DIGITS decimal digits, each applied as acc*10+d. `@` with ≥1 digit → PC. Time error if (time & ((freq>>1)-1)) ≠ 0.
- PC: exactly 8 hex digits, then `:` → SP_A. A 9th digit or an early `:` → IDLE. Pc error if pc is outside [PC_LO,PC_HI] or pc[1:0]≠0.
- SP_A: spaces stay here. `$` → GRF with fmt=01. `*` → ADDR with fmt=10.
- GRF: 1..GRF_DIGITS decimal digits. Space → SP_B; `<` → ARROW. Grf error if grf>GRF_MAX.
- ADDR: exactly 8 hex digits. Space → SP_B; `<` → ARROW. Addr error if the addr is out of range or misaligned.
- SP_B: spaces stay here; `<` → ARROW. ARROW: `=` → SP_C. SP_C: spaces stay here; a hex digit → DATA.
- DATA: exactly 8 hex digits total, then `#`. Data is accumulated. On `#`, bit4 is set if fmt=01, grf=0 and data≠0. The line then completes and the FSM returns to IDLE.
- Error bits for a field are computed when that field's terminator is accepted. Bits not applicable to the format stay 0.

## Timing
- Reset: state IDLE; accumulators, fmt and pending error 0; result_valid=0, format_type=00, error_code=0, counters 0.
- The `#` accepted at edge N gives result_valid=1 in cycle N+1, exactly one cycle.
- format_type and error_code are registered at edge N and held until the next completed line or reset. A later aborted line does not change them.
- Reset asserted mid-line discards the line with no result.
- A `^` arriving in the cycle right after `#` starts a new line normally.

## Configuration
- CPU_TRACE_STATS_EN defined: line_count and err_line_count increment on each completion and saturate at 16'hffff.
- CPU_TRACE_STATS_EN undefined: both ports are driven constant 0 and no counter registers exist.

## Structure
- Package cpu_trace_pkg holds the state enum, format codes 01/10, error bit indices, and ASCII constants for `^ @ : $ * < = # space`.
- Sub-module trace_char_decode, combinational: char → is_dec, is_hex, 4-bit nibble value. It is instantiated once.

## Test plan
- `^10@00003000: $1 <= 0000000a#`, freq=4 → pulse; format_type=01, error_code=00000.
- `^3@00003002: *00003000 <= 00000001#`, freq=4 → format_type=10, error_code=00111.
- `^8@00003004: $32 <= 00000000#` then `^8@00003004: $0 <= 00000005#`, freq=16 → error_code 01000, then 10000.
- `^1@0000` followed by `^2@00003000: $2 <= 12345678#`, freq=2 → exactly one pulse; format_type=01, error_code=0.
- PC with 7 digits, data with 9 digits, and an uppercase `A` in pc → no pulse for any of them; outputs keep their prior values.
- With CPU_TRACE_STATS_EN, 3 good lines and 2 errored lines → line_count=5, err_line_count=2. Reset mid-line → all counters return to 0.

Source files
------------

// File: rtl/cpu_trace_checker_pkg.sv
// Shared types and constants for the CPU trace line checker.
package cpu_trace_pkg;

   typedef enum logic [3:0] {
      S_IDLE,
      S_TIME,
      S_PC,
      S_SP_A,
      S_GRF,
      S_ADDR,
      S_SP_B,
      S_ARROW,
      S_SP_C,
      S_DATA
   } state_e;

   localparam logic [1:0] FMT_NONE = 2'b00;
   localparam logic [1:0] FMT_REG  = 2'b01;
   localparam logic [1:0] FMT_MEM  = 2'b10;

   localparam int ERR_TIME = 0;
   localparam int ERR_PC   = 1;
   localparam int ERR_ADDR = 2;
   localparam int ERR_GRF  = 3;
   localparam int ERR_ZERO = 4;

   localparam logic [7:0] CH_CARET  = 8'h5e;
   localparam logic [7:0] CH_AT     = 8'h40;
   localparam logic [7:0] CH_COLON  = 8'h3a;
   localparam logic [7:0] CH_DOLLAR = 8'h24;
   localparam logic [7:0] CH_STAR   = 8'h2a;
   localparam logic [7:0] CH_LT     = 8'h3c;
   localparam logic [7:0] CH_EQ     = 8'h3d;
   localparam logic [7:0] CH_HASH   = 8'h23;
   localparam logic [7:0] CH_SPACE  = 8'h20;

   localparam logic [7:0] HEX_DIGITS = 8'd8;

endpackage

// File: rtl/trace_char_decode.sv
// Classifies one ASCII char as decimal / lowercase-hex digit and
// returns its nibble value.
module trace_char_decode (
   input  logic [7:0] char,
   output logic       is_dec,
   output logic       is_hex,
   output logic [3:0] nibble
);

   logic is_af;

   always_comb begin
      is_dec = (char >= 8'h30) && (char <= 8'h39);
      is_af  = (char >= 8'h61) && (char <= 8'h66);
      is_hex = is_dec || is_af;
      nibble = 4'd0;
      if (is_dec) nibble = char[3:0];
      else if (is_af) nibble = char[3:0] + 4'd9;
   end

endmodule

// File: rtl/cpu_trace_checker.sv
// CPU trace line checker: parses register/memory write lines.
// Optional stats counters enabled by CPU_TRACE_STATS_EN.
module cpu_trace_checker
   import cpu_trace_pkg::*;
#(
   parameter int          TIME_DIGITS = 4,
   parameter int          TIME_W      = 16,
   parameter int          GRF_DIGITS  = 4,
   parameter int          GRF_MAX     = 31,
   parameter logic [31:0] PC_LO       = 32'h3000,
   parameter logic [31:0] PC_HI       = 32'h4fff,
   parameter logic [31:0] ADDR_LO     = 32'h0,
   parameter logic [31:0] ADDR_HI     = 32'h2fff
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        char_valid,
   input  logic [7:0]  char,
   input  logic [15:0] freq,
   output logic        result_valid,
   output logic [1:0]  format_type,
   output logic [4:0]  error_code,
   output logic [15:0] line_count,
   output logic [15:0] err_line_count
);

   state_e            state_q, state_d;
   logic [TIME_W-1:0] time_q, time_d;
   logic [31:0]       pc_q, pc_d;
   logic [31:0]       grf_q, grf_d;
   logic [31:0]       addr_q, addr_d;
   logic [31:0]       data_q, data_d;
   logic [7:0]        cnt_q, cnt_d;
   logic [1:0]        fmt_q, fmt_d;
   logic [4:0]        err_q, err_d;
   logic              rv_q, rv_d;
   logic [1:0]        ftype_q, ftype_d;
   logic [4:0]        ecode_q, ecode_d;

   logic              is_dec, is_hex;
   logic [3:0]        nib;
   logic [31:0]       tmask;
   logic              time_bad, pc_bad, addr_bad, grf_bad, zero_bad;
   logic              is_sp;

   trace_char_decode u_dec (
      .char   (char),
      .is_dec (is_dec),
      .is_hex (is_hex),
      .nibble (nib)
   );

   // freq is a power of two, so the half-period mask is freq/2 - 1
   always_comb begin
      tmask    = 32'(freq >> 1) - 32'd1;
      time_bad = (32'(time_q) & tmask) != 32'd0;
      pc_bad   = (pc_q < PC_LO) || (pc_q > PC_HI) || (pc_q[1:0] != 2'b00);
      addr_bad = (addr_q < ADDR_LO) || (addr_q > ADDR_HI)
                 || (addr_q[1:0] != 2'b00);
      grf_bad  = grf_q > 32'(GRF_MAX);
      zero_bad = (fmt_q == FMT_REG) && (grf_q == 32'd0)
                 && (data_q != 32'd0);
      is_sp    = char == CH_SPACE;
   end

   always_comb begin
      state_d = state_q;
      time_d  = time_q;
      pc_d    = pc_q;
      grf_d   = grf_q;
      addr_d  = addr_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
      fmt_d   = fmt_q;
      err_d   = err_q;
      rv_d    = 1'b0;
      ftype_d = ftype_q;
      ecode_d = ecode_q;
      if (char_valid) begin
         if (char == CH_CARET) begin
            state_d = S_TIME;
            time_d  = '0;
            pc_d    = '0;
            grf_d   = '0;
            addr_d  = '0;
            data_d  = '0;
            cnt_d   = '0;
            fmt_d   = FMT_NONE;
            err_d   = '0;
         end else begin
            // anything not accepted below drops the line
            state_d = S_IDLE;
            unique case (state_q)
               S_TIME: begin
                  if (is_dec && cnt_q < 8'(TIME_DIGITS)) begin
                     state_d = S_TIME;
                     time_d  = (time_q << 3) + (time_q << 1) + TIME_W'(nib);
                     cnt_d   = cnt_q + 8'd1;
                  end else if (char == CH_AT && cnt_q != 8'd0) begin
                     state_d         = S_PC;
                     cnt_d           = '0;
                     err_d[ERR_TIME] = time_bad;
                  end
               end
               S_PC: begin
                  if (is_hex && cnt_q < HEX_DIGITS) begin
                     state_d = S_PC;
                     pc_d    = {pc_q[27:0], nib};
                     cnt_d   = cnt_q + 8'd1;
                  end else if (char == CH_COLON && cnt_q == HEX_DIGITS) begin
                     state_d       = S_SP_A;
                     cnt_d         = '0;
                     err_d[ERR_PC] = pc_bad;
                  end
               end
               S_SP_A: begin
                  if (is_sp) begin
                     state_d = S_SP_A;
                  end else if (char == CH_DOLLAR) begin
                     state_d = S_GRF;
                     fmt_d   = FMT_REG;
                  end else if (char == CH_STAR) begin
                     state_d = S_ADDR;
                     fmt_d   = FMT_MEM;
                  end
               end
               S_GRF: begin
                  if (is_dec && cnt_q < 8'(GRF_DIGITS)) begin
                     state_d = S_GRF;
                     grf_d   = (grf_q << 3) + (grf_q << 1) + 32'(nib);
                     cnt_d   = cnt_q + 8'd1;
                  end else if ((is_sp || char == CH_LT) && cnt_q != 8'd0) begin
                     state_d        = is_sp ? S_SP_B : S_ARROW;
                     cnt_d          = '0;
                     err_d[ERR_GRF] = grf_bad;
                  end
               end
               S_ADDR: begin
                  if (is_hex && cnt_q < HEX_DIGITS) begin
                     state_d = S_ADDR;
                     addr_d  = {addr_q[27:0], nib};
                     cnt_d   = cnt_q + 8'd1;
                  end else if ((is_sp || char == CH_LT)
                               && cnt_q == HEX_DIGITS) begin
                     state_d         = is_sp ? S_SP_B : S_ARROW;
                     cnt_d           = '0;
                     err_d[ERR_ADDR] = addr_bad;
                  end
               end
               S_SP_B: begin
                  if (is_sp) state_d = S_SP_B;
                  else if (char == CH_LT) state_d = S_ARROW;
               end
               S_ARROW: begin
                  if (char == CH_EQ) state_d = S_SP_C;
               end
               S_SP_C: begin
                  if (is_sp) begin
                     state_d = S_SP_C;
                  end else if (is_hex) begin
                     state_d = S_DATA;
                     data_d  = {data_q[27:0], nib};
                     cnt_d   = 8'd1;
                  end
               end
               S_DATA: begin
                  if (is_hex && cnt_q < HEX_DIGITS) begin
                     state_d = S_DATA;
                     data_d  = {data_q[27:0], nib};
                     cnt_d   = cnt_q + 8'd1;
                  end else if (char == CH_HASH && cnt_q == HEX_DIGITS) begin
                     rv_d              = 1'b1;
                     ftype_d           = fmt_q;
                     ecode_d           = err_q;
                     ecode_d[ERR_ZERO] = zero_bad;
                  end
               end
               default: state_d = S_IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         time_q  <= '0;
         pc_q    <= '0;
         grf_q   <= '0;
         addr_q  <= '0;
         data_q  <= '0;
         cnt_q   <= '0;
         fmt_q   <= FMT_NONE;
         err_q   <= '0;
         rv_q    <= 1'b0;
         ftype_q <= FMT_NONE;
         ecode_q <= '0;
      end else begin
         state_q <= state_d;
         time_q  <= time_d;
         pc_q    <= pc_d;
         grf_q   <= grf_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
         fmt_q   <= fmt_d;
         err_q   <= err_d;
         rv_q    <= rv_d;
         ftype_q <= ftype_d;
         ecode_q <= ecode_d;
      end
   end

   assign result_valid = rv_q;
   assign format_type  = ftype_q;
   assign error_code   = ecode_q;

`ifdef CPU_TRACE_STATS_EN
   logic [15:0] lines_q, lines_d;
   logic [15:0] elines_q, elines_d;

   always_comb begin
      lines_d  = lines_q;
      elines_d = elines_q;
      if (rv_d && lines_q != 16'hffff) lines_d = lines_q + 16'd1;
      if (rv_d && ecode_d != 5'd0 && elines_q != 16'hffff)
         elines_d = elines_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         lines_q  <= '0;
         elines_q <= '0;
      end else begin
         lines_q  <= lines_d;
         elines_q <= elines_d;
      end
   end

   assign line_count     = lines_q;
   assign err_line_count = elines_q;
`else
   assign line_count     = 16'd0;
   assign err_line_count = 16'd0;
`endif

endmodule

// File: tb/tb_cpu_trace_checker.sv
// Scoreboard bench for cpu_trace_checker: directed trace lines,
// expected {format,error} queued at issue, popped on result_valid.
module tb_cpu_trace_checker;

   logic        clk = 1'b0;
   logic        reset;
   logic        char_valid;
   logic [7:0]  char;
   logic [15:0] freq;
   logic        result_valid;
   logic [1:0]  format_type;
   logic [4:0]  error_code;
   logic [15:0] line_count;
   logic [15:0] err_line_count;

   int n_cmp = 0;
   int n_bad = 0;
   logic [6:0] exp_q[$];
   logic [1:0] last_fmt;
   logic [4:0] last_err;

   cpu_trace_checker dut (
      .clk            (clk),
      .reset          (reset),
      .char_valid     (char_valid),
      .char           (char),
      .freq           (freq),
      .result_valid   (result_valid),
      .format_type    (format_type),
      .error_code     (error_code),
      .line_count     (line_count),
      .err_line_count (err_line_count)
   );

   always #5 clk = ~clk;

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (reset === 1'b0 && result_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_pulse: got fmt=%b err=%b expected none",
                     format_type, error_code);
         end else begin
            logic [6:0] e;
            e = exp_q.pop_front();
            check("format_type", 32'(format_type), 32'(e[6:5]));
            check("error_code", 32'(error_code), 32'(e[4:0]));
         end
      end
   end

   task automatic idle(int n);
      char_valid = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(string s, bit gaps = 1'b0);
      for (int i = 0; i < s.len(); i++) begin
         char_valid = 1'b1;
         char       = s[i];
         @(posedge clk);
         #1;
         if (gaps) begin
            char_valid = 1'b0;
            char       = 8'h5e;
            @(posedge clk);
            #1;
         end
      end
      char_valid = 1'b0;
   endtask

   task automatic expect_line(logic [1:0] f, logic [4:0] e);
      exp_q.push_back({f, e});
      last_fmt = f;
      last_err = e;
   endtask

   task automatic line(string s, logic [1:0] f, logic [4:0] e);
      expect_line(f, e);
      send(s);
      idle(2);
   endtask

   task automatic abort_line(string name, string s);
      send(s);
      idle(3);
      check({name, "_fmt_hold"}, 32'(format_type), 32'(last_fmt));
      check({name, "_err_hold"}, 32'(error_code), 32'(last_err));
   endtask

   task automatic check_stats(string name, int lc, int elc);
`ifdef CPU_TRACE_STATS_EN
      check({name, "_line_count"}, 32'(line_count), 32'(lc));
      check({name, "_err_line_count"}, 32'(err_line_count), 32'(elc));
`else
      check({name, "_line_count"}, 32'(line_count), 32'd0 & 32'(lc));
      check({name, "_err_line_count"}, 32'(err_line_count), 32'd0 & 32'(elc));
`endif
   endtask

   initial begin
      reset      = 1'b1;
      char_valid = 1'b0;
      char       = 8'h00;
      freq       = 16'd4;
      last_fmt   = 2'b00;
      last_err   = 5'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_result_valid", 32'(result_valid), 32'd0);
      check("reset_format_type", 32'(format_type), 32'd0);
      check("reset_error_code", 32'(error_code), 32'd0);
      check_stats("reset", 0, 0);
      reset = 1'b0;
      idle(2);

      freq = 16'd4;
      line("^10@00003000: $1 <= 0000000a#", 2'b01, 5'b00000);
      line("^3@00003002: *00003000 <= 00000001#", 2'b10, 5'b00111);

      freq = 16'd16;
      expect_line(2'b01, 5'b01000);
      expect_line(2'b01, 5'b10000);
      send({"^8@00003004: $32 <= 00000000#",
            "^8@00003004: $0 <= 00000005#"});
      idle(2);

      freq = 16'd2;
      line("^1@0000^2@00003000: $2 <= 12345678#", 2'b01, 5'b00000);

      freq = 16'd4;
      expect_line(2'b10, 5'b00000);
      send("^4@00004ffc: *00002ffc <= deadbeef#", 1'b1);
      idle(2);

      freq = 16'd8;
      line("^12@00005000: $31 <= 00000000#", 2'b01, 5'b00010);

      abort_line("pc7", "^5@0000300: $1 <= 00000000#");
      abort_line("data9", "^5@00003000: $1 <= 000000000#");
      abort_line("upper", "^5@0000A000: $1 <= 00000000#");
      abort_line("time5", "^12345@00003000: $1 <= 00000000#");
      check_stats("first_batch", 7, 4);

      send("^7@000030");
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      send("00: $1 <= 00000000#");
      idle(3);
      check("midreset_format_type", 32'(format_type), 32'd0);
      check("midreset_error_code", 32'(error_code), 32'd0);
      check_stats("midreset", 0, 0);
      last_fmt = 2'b00;
      last_err = 5'b0;

      freq = 16'd2;
      line("^0@00003000: $0 <= 00000000#", 2'b01, 5'b00000);
      freq = 16'd16;
      line("^8@00003ffc: *00000000 <= ffffffff#", 2'b10, 5'b00000);
      freq = 16'd2;
      line("^9999@00004ffc: $31 <= 00000001#", 2'b01, 5'b00000);
      freq = 16'd4;
      line("^1@00003000: *00003000 <= 00000000#", 2'b10, 5'b00101);
      line("^6@00003000: $0 <= 00000001#", 2'b01, 5'b10000);
      check_stats("second_batch", 5, 2);
      check("final_format_hold", 32'(format_type), 32'(last_fmt));
      check("final_error_hold", 32'(error_code), 32'(last_err));

      idle(4);
      check("pending_results", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
